// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NOP_INSTR  = 0;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StHold = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction/pc buffer that parks a fetch response while decode is stalled.
module fetch_skid #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc;

    // Clear wins over load; both are never requested together by the fetch FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem reads, redirect on flush, skid on stall,
// and the IF_ID pipeline register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_PC_ID,
    input  logic              flush_ID,
    input  logic [ADDR_W-1:0] new_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              IF_ID_valid,
    output logic [DATA_W-1:0] IF_ID_instr,
    output logic [ADDR_W-1:0] IF_ID_pc
);

    fetch_state_e      r_state, w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_next;
    logic [ADDR_W-1:0] r_drop_addr, w_drop_addr_next;
    logic              r_if_valid, w_if_valid_next;
    logic [DATA_W-1:0] r_if_instr, w_if_instr_next;
    logic [ADDR_W-1:0] r_if_pc, w_if_pc_next;

    logic              w_skid_load, w_skid_clear, w_skid_valid;
    logic [DATA_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0] w_skid_pc;
    logic              w_load_mem, w_load_skid;

    fetch_skid #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (imem_rdata),
        .i_pc    (r_fetch_pc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_comb begin
        w_state_next     = r_state;
        w_fetch_pc_next  = r_fetch_pc;
        w_drop_addr_next = r_drop_addr;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        w_load_mem       = 1'b0;
        w_load_skid      = 1'b0;

        unique case (r_state)
            StReq: begin
                if (flush_ID) begin
                    w_fetch_pc_next = new_pc;
                    // Without a response in hand the old request is still in flight.
                    if (!imem_valid) begin
                        w_drop_addr_next = r_fetch_pc;
                        w_state_next     = StDrop;
                    end
                end else if (imem_valid) begin
                    w_fetch_pc_next = r_fetch_pc + ADDR_W'(1);
                    if (stall_PC_ID) begin
                        w_skid_load  = 1'b1;
                        w_state_next = StHold;
                    end else begin
                        w_load_mem = 1'b1;
                    end
                end
            end
            StHold: begin
                if (flush_ID) begin
                    w_skid_clear    = 1'b1;
                    w_fetch_pc_next = new_pc;
                    w_state_next    = StReq;
                end else if (!stall_PC_ID && w_skid_valid) begin
                    w_load_skid  = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_next = StReq;
                end
            end
            StDrop: begin
                if (flush_ID) begin
                    w_fetch_pc_next = new_pc;
                end
                if (imem_valid) begin
                    w_state_next = StReq;
                end
            end
            default: w_state_next = StReq;
        endcase

        w_if_valid_next = r_if_valid;
        w_if_instr_next = r_if_instr;
        w_if_pc_next    = r_if_pc;
        if (flush_ID) begin
            w_if_valid_next = 1'b0;
            w_if_instr_next = DATA_W'(NOP_INSTR);
        end else if (stall_PC_ID) begin
            w_if_valid_next = r_if_valid;
        end else if (w_load_mem) begin
            w_if_valid_next = 1'b1;
            w_if_instr_next = imem_rdata;
            w_if_pc_next    = r_fetch_pc;
        end else if (w_load_skid) begin
            w_if_valid_next = 1'b1;
            w_if_instr_next = w_skid_instr;
            w_if_pc_next    = w_skid_pc;
        end else begin
            w_if_valid_next = 1'b0;
            w_if_instr_next = DATA_W'(NOP_INSTR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StReq;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= '0;
            r_if_valid  <= 1'b0;
            r_if_instr  <= DATA_W'(NOP_INSTR);
            r_if_pc     <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_drop_addr <= w_drop_addr_next;
            r_if_valid  <= w_if_valid_next;
            r_if_instr  <= w_if_instr_next;
            r_if_pc     <= w_if_pc_next;
        end
    end

    assign imem_req    = !rst && (r_state != StHold);
    assign imem_addr   = (r_state == StDrop) ? r_drop_addr : r_fetch_pc;
    assign IF_ID_valid = r_if_valid;
    assign IF_ID_instr = r_if_instr;
    assign IF_ID_pc    = r_if_pc;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage feeding the IF_ID pipeline register, directly upstream of the hazard detection unit. Holds the fetch PC and issues one-outstanding-request reads to instruction memory with a req/valid handshake. Obeys stall_PC_ID and flush_ID from hazard detection and redirects to a new PC on change of flow. A one-entry skid buffer absorbs a response that arrives while decode is stalled.

## Interface
- ADDR_W, 16, PC / instruction-memory word-address width (word addressed, PC increments by 1)
- DATA_W, 32, instruction width
- RESET_PC, 0, fetch address after reset
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall_PC_ID  in  1  from hazard detect: hold fetch PC and IF_ID
- flush_ID  in  1  from hazard detect (change of flow): clear IF_ID, redirect fetch to new_pc
- new_pc  in  ADDR_W  redirect target, sampled only when flush_ID=1
- imem_req  out  1  read request; held with imem_addr stable until imem_valid
- imem_addr  out  ADDR_W  read address
- imem_valid  in  1  response strobe; legal only while imem_req=1, may arrive in the request cycle (zero-wait memory)
- imem_rdata  in  DATA_W  instruction, valid with imem_valid
- IF_ID_valid  out  1  IF_ID holds a real instruction
- IF_ID_instr  out  DATA_W  registered instruction (NOP=0 when invalid)
- IF_ID_pc  out  ADDR_W  address of IF_ID_instr

## Operation
- Registers: state, fetch_pc (next/current request address), drop_addr, skid_instr, skid_pc, IF_ID_{valid,instr,pc}.
- States:
  - REQ: imem_req=1, imem_addr=fetch_pc.
  - HOLD: imem_req=0; skid holds one fetched instruction.
  - DROP: imem_req=1, imem_addr=drop_addr; response will be discarded.
- REQ:
  - flush_ID: fetch_pc<=new_pc; if imem_valid, response dropped, stay REQ; else drop_addr<=fetch_pc, go DROP.
  - imem_valid and !stall_PC_ID: IF_ID loads {1, imem_rdata, fetch_pc}; fetch_pc<=fetch_pc+1.
  - imem_valid and stall_PC_ID: skid<={imem_rdata, fetch_pc}; fetch_pc<=fetch_pc+1; go HOLD.
  - no imem_valid: stay.
- HOLD:
  - flush_ID: skid discarded; fetch_pc<=new_pc; go REQ.
  - !stall_PC_ID: IF_ID loads {1, skid}; go REQ.
  - Else stay.
- DROP:
  - flush_ID: fetch_pc<=new_pc.
  - imem_valid: response discarded; go REQ.
- IF_ID update priority:
  1. rst
  2. flush_ID: valid=0, instr=0, pc unchanged
  3. stall_PC_ID: hold
  4. load as above
  5. else bubble: valid=0, instr=0
- fetch_pc+1 wraps modulo 2^ADDR_W (0xFFFF -> 0x0000 at default).
- flush_ID and stall_PC_ID together: flush wins.

## Timing
- Reset (rst high at edge):
  - state=REQ, fetch_pc=RESET_PC, IF_ID_valid=0, IF_ID_instr=0, IF_ID_pc=RESET_PC, skid cleared.
  - imem_req forced 0 while rst=1.
  - Any outstanding request is abandoned; memory must tolerate this.
- Zero-wait memory, no stalls: one instruction per cycle into IF_ID; request at cycle t appears in IF_ID at t+1.
- Redirect:
  - flush_ID at t in REQ with imem_valid (or in HOLD): request to new_pc at t+1; IF_ID valid at t+2 with zero-wait memory.
  - In DROP: new request the cycle after the stale imem_valid.
- Stall release from HOLD: IF_ID gets skid at the release edge; next request issues the same cycle state returns to REQ.
- Never more than one request outstanding.
- imem_addr never changes while imem_req=1 and imem_valid=0.

## Structure
- Shared package (cpu_pkg):
  - fetch state enum {REQ, HOLD, DROP}
  - NOP_INSTR constant (0)
  - default ADDR_W/DATA_W
- One natural sub-module: fetch_skid (one-entry instr+pc buffer with load/clear/valid). The FSM stays in fetch_stage.
- Target size ~150-250 lines of RTL.

## Test plan
- Reset then zero-wait memory returning rdata=0x1000_0000+addr: IF_ID_pc steps 0,1,2,3 on consecutive cycles, IF_ID_valid=1 from the 2nd cycle after reset release.
- Stall: stall_PC_ID=1 for 3 cycles while imem_valid=1 at addr 5 -> state HOLD, imem_req=0, IF_ID holds; on release IF_ID_pc=5, next request addr 6.
- Redirect with 3-cycle memory latency: flush_ID, new_pc=0x40 one cycle after request to addr 8 -> DROP, addr 8 held until valid; IF_ID never shows pc 8; next request addr 0x40.
- flush_ID and stall_PC_ID same cycle in HOLD -> skid discarded, IF_ID_valid=0, next request to new_pc.
- Wrap: fetch_pc=0xFFFF, zero-wait -> IF_ID_pc 0xFFFF then 0x0000.
- rst asserted mid-DROP with outstanding request -> next cycle imem_req=1, imem_addr=RESET_PC, IF_ID_valid=0.
